// File: rtl/palette_bank_ram_if.sv
// Bus bundle for palette_bank_ram: CPU write side, display read ports, swap/clear control and status.
interface palette_bank_ram_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned NUM_RD = 2
);
    logic                       wr_en;
    logic [ADDR_W-1:0]          wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic [DATA_W/8-1:0]        wr_be;
    logic [NUM_RD*ADDR_W-1:0]   rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic                       clear_req;
    logic                       swap_req;
    logic                       vsync;
    logic                       front_bank;
    logic                       swap_pending;
    logic                       busy;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, rd_addr, clear_req, swap_req, vsync,
        input  rd_data, front_bank, swap_pending, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, rd_addr, clear_req, swap_req, vsync,
        output rd_data, front_bank, swap_pending, busy
    );
endinterface

// File: rtl/palette_bank_ram.sv
// Double-buffered palette RAM: CPU fills the back bank, display pipes read the front bank,
// bank exchange is deferred to vsync rise, and a sequencer zero-fills banks instead of an array reset.
module palette_bank_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                clk,
    input  logic                rst,
    palette_bank_ram_if.slave   bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned NB    = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    state_t                     r_state;
    logic [ADDR_W-1:0]          r_clr_cnt;
    logic                       r_busy;
    logic                       r_front_bank;
    logic                       r_swap_pending;
    logic                       r_vsync_q;
    logic [NUM_RD*DATA_W-1:0]   r_rd_data;

    logic                       w_vs_rise;
    logic                       w_do_swap;
    logic                       w_last;
    logic                       w_we0;
    logic                       w_we1;
    logic [ADDR_W-1:0]          w_waddr;
    logic [DATA_W-1:0]          w_wdata;
    logic [NB-1:0]              w_wbe;
    logic [NUM_RD*DATA_W-1:0]   w_rd_word;

    assign w_vs_rise = bus.vsync & ~r_vsync_q;
    assign w_do_swap = w_vs_rise & (r_swap_pending | bus.swap_req) & ~r_busy;
    assign w_last    = (r_clr_cnt == ADDR_W'(DEPTH - 1));

    // Write-port decode: sequencer zero-fill or CPU byte-enabled write into the back bank.
    always_comb begin
        w_we0   = 1'b0;
        w_we1   = 1'b0;
        w_waddr = r_clr_cnt;
        w_wdata = '0;
        w_wbe   = '1;
        case (r_state)
            ST_INIT: begin
                w_we0 = 1'b1;
                w_we1 = 1'b1;
            end
            ST_CLEAR: begin
                w_we0 = r_front_bank;
                w_we1 = ~r_front_bank;
            end
            ST_IDLE: begin
                if (bus.wr_en) begin
                    w_we0   = r_front_bank;
                    w_we1   = ~r_front_bank;
                    w_waddr = bus.wr_addr;
                    w_wdata = bus.wr_data;
                    w_wbe   = bus.wr_be;
                end
            end
            default: ;
        endcase
    end

    // One storage array per byte lane per bank, so byte enables map to plain lane write enables.
    for (genvar k = 0; k < NB; k++) begin : g_lane
        logic [7:0] r_mem0 [DEPTH];
        logic [7:0] r_mem1 [DEPTH];

        always_ff @(posedge clk) begin
            if (w_we0 && w_wbe[k]) r_mem0[w_waddr] <= w_wdata[k*8 +: 8];
            if (w_we1 && w_wbe[k]) r_mem1[w_waddr] <= w_wdata[k*8 +: 8];
        end

        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [ADDR_W-1:0] w_ra;
            assign w_ra = bus.rd_addr[p*ADDR_W +: ADDR_W];
            assign w_rd_word[p*DATA_W + k*8 +: 8] = r_front_bank ? r_mem1[w_ra] : r_mem0[w_ra];
        end
    end

    // Sequencer FSM, swap control and registered read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_INIT;
            r_clr_cnt      <= '0;
            r_busy         <= 1'b1;
            r_front_bank   <= 1'b0;
            r_swap_pending <= 1'b0;
            r_vsync_q      <= 1'b0;
            r_rd_data      <= '0;
        end else begin
            r_vsync_q <= bus.vsync;
            r_rd_data <= (r_state == ST_INIT) ? '0 : w_rd_word;

            if (w_do_swap) begin
                r_front_bank   <= ~r_front_bank;
                r_swap_pending <= 1'b0;
            end else if (bus.swap_req) begin
                r_swap_pending <= 1'b1;
            end

            case (r_state)
                ST_INIT, ST_CLEAR: begin
                    if (w_last) begin
                        r_state   <= ST_IDLE;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (bus.clear_req) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_INIT;
                    r_clr_cnt <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rd_data      = r_rd_data;
    assign bus.front_bank   = r_front_bank;
    assign bus.swap_pending = r_swap_pending;
    assign bus.busy         = r_busy;

endmodule

// File: tb/tb_palette_bank_ram.sv
// Scoreboard bench for palette_bank_ram: shadow banks predict reads, queue holds pending read results.
module tb_palette_bank_ram;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned DEPTH  = 1 << ADDR_W;

    logic clk;
    logic rst;

    palette_bank_ram_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) bus ();

    palette_bank_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    logic [15:0] m_bank [2][DEPTH];
    bit          m_front;
    logic [15:0] sb_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic m_zero(input bit b);
        for (int i = 0; i < int'(DEPTH); i++) m_bank[b][i] = 16'h0000;
    endtask

    task automatic wr(input logic [9:0] a, input logic [15:0] d, input logic [1:0] be);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        bus.wr_be   = be;
        tick();
        bus.wr_en   = 1'b0;
        for (int k = 0; k < 2; k++)
            if (be[k]) m_bank[~m_front][a][k*8 +: 8] = d[k*8 +: 8];
    endtask

    task automatic rd2(input logic [9:0] a0, input logic [9:0] a1, input string tag);
        logic [15:0] exp_v;
        logic [15:0] got_v;
        bus.rd_addr = {a1, a0};
        sb_q.push_back(m_bank[m_front][a0]);
        sb_q.push_back(m_bank[m_front][a1]);
        tick();
        for (int p = 0; p < 2; p++) begin
            exp_v = sb_q.pop_front();
            got_v = bus.rd_data[p*16 +: 16];
            n_vec++;
            if (got_v !== exp_v) begin
                n_err++;
                $display("FAIL %s port%0d: got %h expected %h", tag, p, got_v, exp_v);
            end
        end
    endtask

    task automatic swap_now(input string tag);
        bus.swap_req = 1'b1;
        bus.vsync    = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        bus.vsync    = 1'b0;
        m_front      = ~m_front;
        n_vec++;
        if (bus.front_bank !== m_front || bus.swap_pending !== 1'b0) begin
            n_err++;
            $display("FAIL %s: front/pending got %b/%b expected %b/0", tag,
                     bus.front_bank, bus.swap_pending, m_front);
        end
        tick();
    endtask

    task automatic wait_busy_low(output int n);
        n = 0;
        while (bus.busy === 1'b1 && n < 3000) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        n_vec++;
        if (bus.busy !== 1'b1 || bus.front_bank !== 1'b0 || bus.swap_pending !== 1'b0 ||
            bus.rd_data !== 32'h0) begin
            n_err++;
            $display("FAIL %s: busy/front/pend/rd got %b/%b/%b/%h expected 1/0/0/00000000", tag,
                     bus.busy, bus.front_bank, bus.swap_pending, bus.rd_data);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp_v);
        n_vec++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp_v);
        end
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 check_reset_vals("reset_values");
        tick();
        rst = 1'b1;
        wait_busy_low(n);
        check_int("init_busy_cycles", n, int'(DEPTH));
        m_zero(1'b0);
        m_zero(1'b1);
        m_front = 1'b0;
        rd2(10'd0, 10'd1023, "init_bank0_a");
        swap_now("init_swap1");
        rd2(10'd5, 10'd512, "init_bank1");
        swap_now("init_swap2");
        rd2(10'd777, 10'd1, "init_bank0_b");
    endtask

    task automatic test_write_be();
        wr(10'd5, 16'hABCD, 2'b11);
        wr(10'd5, 16'h1200, 2'b10);
        wr(10'd6, 16'hBEEF, 2'b00);
        rd2(10'd5, 10'd5, "front_unaltered_by_write");
    endtask

    task automatic test_deferred_swap();
        int bad;
        bit f0;
        f0 = m_front;
        repeat (8) tick();
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.swap_pending !== 1'b1 || bus.front_bank !== f0) bad++;
            tick();
        end
        check_int("pending_hold_cycles_bad", bad, 0);
        bus.vsync = 1'b1;
        tick();
        bus.vsync = 1'b0;
        m_front   = ~m_front;
        n_vec++;
        if (bus.front_bank !== m_front || bus.swap_pending !== 1'b0) begin
            n_err++;
            $display("FAIL deferred_swap: front/pending got %b/%b expected %b/0",
                     bus.front_bank, bus.swap_pending, m_front);
        end
        rd2(10'd5, 10'd6, "read_after_swap");
    endtask

    task automatic test_swap_coincident();
        int n;
        bus.swap_req = 1'b1;
        bus.vsync    = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        bus.vsync    = 1'b0;
        m_front      = ~m_front;
        n_vec++;
        if (bus.front_bank !== m_front || bus.swap_pending !== 1'b0) begin
            n_err++;
            $display("FAIL coincident_swap_idle: front/pending got %b/%b expected %b/0",
                     bus.front_bank, bus.swap_pending, m_front);
        end
        tick();
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        m_zero(~m_front);
        bus.swap_req = 1'b1;
        bus.vsync    = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        bus.vsync    = 1'b0;
        n_vec++;
        if (bus.busy !== 1'b1 || bus.front_bank !== m_front || bus.swap_pending !== 1'b1) begin
            n_err++;
            $display("FAIL coincident_swap_busy: busy/front/pend got %b/%b/%b expected 1/%b/1",
                     bus.busy, bus.front_bank, bus.swap_pending, m_front);
        end
        wait_busy_low(n);
        check_int("clear_finished_in_bound", int'(n < 3000), 1);
        check_int("pending_after_busy", int'(bus.swap_pending), 1);
        bus.vsync = 1'b1;
        tick();
        bus.vsync = 1'b0;
        m_front   = ~m_front;
        check_int("deferred_front_after_busy", int'(bus.front_bank), int'(m_front));
        check_int("pending_cleared_after_busy", int'(bus.swap_pending), 0);
        tick();
    endtask

    task automatic test_clear();
        int n;
        for (int a = 0; a < int'(DEPTH); a++) wr(10'(a), 16'hFFFF, 2'b11);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        m_zero(~m_front);
        n = 0;
        while (bus.busy === 1'b1 && n < 3000) begin
            if (n == 500) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = 10'd0;
                bus.wr_data = 16'hFFFF;
                bus.wr_be   = 2'b11;
            end
            tick();
            bus.wr_en = 1'b0;
            n++;
        end
        check_int("clear_busy_cycles", n, int'(DEPTH));
        swap_now("clear_swap");
        rd2(10'd0, 10'd511, "cleared_a");
        rd2(10'd1023, 10'd0, "cleared_b");
    endtask

    task automatic test_swap_clear();
        int n;
        wr(10'd7, 16'h5A5A, 2'b11);
        swap_now("sc_swap1");
        wr(10'd7, 16'h3C3C, 2'b11);
        bus.swap_req  = 1'b1;
        bus.vsync     = 1'b1;
        bus.clear_req = 1'b1;
        tick();
        bus.swap_req  = 1'b0;
        bus.vsync     = 1'b0;
        bus.clear_req = 1'b0;
        m_front       = ~m_front;
        m_zero(~m_front);
        n_vec++;
        if (bus.busy !== 1'b1 || bus.front_bank !== m_front) begin
            n_err++;
            $display("FAIL swap_with_clear: busy/front got %b/%b expected 1/%b",
                     bus.busy, bus.front_bank, m_front);
        end
        rd2(10'd7, 10'd7, "swap_clear_new_front");
        wait_busy_low(n);
        tick();
        swap_now("sc_swap2");
        rd2(10'd7, 10'd0, "swap_clear_old_front_cleared");
    endtask

    task automatic test_reset_mid_init();
        int n;
        wr(10'd9, 16'h7777, 2'b11);
        swap_now("mid_swap1");
        if (!m_front) begin
            wr(10'd9, 16'h7777, 2'b11);
            swap_now("mid_swap2");
        end
        rd2(10'd9, 10'd9, "pre_reset_read");
        bus.swap_req = 1'b1;
        tick();
        bus.swap_req = 1'b0;
        #2 rst = 1'b0;
        #1 check_reset_vals("async_reset_idle");
        tick();
        rst = 1'b1;
        repeat (300) tick();
        #2 rst = 1'b0;
        #1 check_reset_vals("async_reset_init300");
        tick();
        rst = 1'b1;
        wait_busy_low(n);
        check_int("reinit_busy_cycles", n, int'(DEPTH));
        m_zero(1'b0);
        m_zero(1'b1);
        m_front = 1'b0;
        rd2(10'd9, 10'd7, "after_reinit");
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        m_front       = 1'b0;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.wr_be     = '0;
        bus.rd_addr   = '0;
        bus.clear_req = 1'b0;
        bus.swap_req  = 1'b0;
        bus.vsync     = 1'b0;
        test_reset();
        test_write_be();
        test_deferred_swap();
        test_swap_coincident();
        test_clear();
        test_swap_clear();
        test_reset_mid_init();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
